// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the SRAM-like port arbiter: requester IDs, access sizes, lock states.
package sram_arbiter_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK_I   = 2'd1,
    LOCK_D   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/sram_arb_idfifo.sv
// 1-bit-wide ID FIFO recording which requester issued each in-flight transaction.
module sram_arb_idfifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             din,
  input  logic             pop,
  output logic             head,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full
);

  logic [DEPTH-1:0] ids;
  logic [PTR_W-1:0] wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = ids[rptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      ids   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        ids[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data access; data wins ties,
// a stalled address phase locks its owner, responses are routed back in issue order.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int PTR_W     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [3:0]       inst_wstrb,
  input  logic [31:0]      inst_addr,
  input  logic [31:0]      inst_wdata,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [31:0]      inst_rdata,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [3:0]       data_wstrb,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [1:0]       mem_size,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_addr_ok,
  input  logic             mem_data_ok,
  input  logic [31:0]      mem_rdata,
  output logic [PTR_W:0]   outst_cnt,
  output logic             err_spurious
);

  lock_state_t state, state_nxt;
  logic        owner_vld, owner_id, owner_req;
  logic        full, empty, head, fire, pop;

  always_comb begin
    owner_vld = 1'b0;
    owner_id  = SRC_INST;
    case (state)
      LOCK_I: begin owner_vld = 1'b1; owner_id = SRC_INST; end
      LOCK_D: begin owner_vld = 1'b1; owner_id = SRC_DATA; end
      default: begin
        if (data_req) begin
          owner_vld = 1'b1;
          owner_id  = SRC_DATA;
        end else if (inst_req) begin
          owner_vld = 1'b1;
          owner_id  = SRC_INST;
        end
      end
    endcase
  end

  assign owner_req = owner_vld & ((owner_id == SRC_DATA) ? data_req : inst_req);
  assign mem_req   = owner_req & ~full;
  assign fire      = mem_req & mem_addr_ok;

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = SIZE_BYTE;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (owner_vld) begin
      if (owner_id == SRC_DATA) begin
        mem_wr = data_wr; mem_size = data_size; mem_wstrb = data_wstrb;
        mem_addr = data_addr; mem_wdata = data_wdata;
      end else begin
        mem_wr = inst_wr; mem_size = inst_size; mem_wstrb = inst_wstrb;
        mem_addr = inst_addr; mem_wdata = inst_wdata;
      end
    end
  end

  assign inst_addr_ok = fire & (owner_id == SRC_INST);
  assign data_addr_ok = fire & (owner_id == SRC_DATA);

  // A refused address phase pins the owner; while full the lock holds so the
  // pending request is not swapped for the other port's.
  always_comb begin
    state_nxt = state;
    if (fire)          state_nxt = UNLOCKED;
    else if (mem_req)  state_nxt = (owner_id == SRC_DATA) ? LOCK_D : LOCK_I;
    else if (!full)    state_nxt = UNLOCKED;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= UNLOCKED;
    else       state <= state_nxt;
  end

  assign pop          = mem_data_ok & ~empty;
  assign inst_data_ok = pop & (head == SRC_INST);
  assign data_data_ok = pop & (head == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset)                     err_spurious <= 1'b0;
    else if (mem_data_ok && empty) err_spurious <= 1'b1;
  end

  sram_arb_idfifo #(.DEPTH(MAX_OUTST), .PTR_W(PTR_W)) u_idfifo (
    .clk   (clk),
    .reset (reset),
    .push  (fire),
    .din   (owner_id),
    .pop   (pop),
    .head  (head),
    .count (outst_cnt),
    .empty (empty),
    .full  (full)
  );

endmodule
